motor_pwm_gen: RTL

Parametrised multi-channel motor PWM generator driving the copter ESC outputs (the `COPTER_MOTOR_PWM` bus), generalised from a fixed 6-channel output to `NUM_CH` channels. It has a programmable period, double-buffered pulse widths committed atomically at period boundaries, arm/disarm control and a refresh watchdog. On watchdog expiry it forces all channels to a safe idle throttle. It sits in the PL between the PS register-bridge logic and the motor pins.

---
 rtl/motor_pwm_gen.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen
// Multi-channel motor PWM generator for the copter ESC outputs.
// A prescaler divides aclk into ticks. A period counter counts ticks from
// 0 to period_q-1. Each channel compares that count against its shadow
// pulse width. Pulse widths are written into a staging bank. A commit copies
// the staging bank into the shadow bank at the next period boundary, so all
// channels change in the same period. A refresh watchdog forces an idle
// throttle on every channel when no commit arrives for WDOG_PERIODS periods.
//
// Ports:
//   aclk          sole clock
//   aresetn       asynchronous active-low reset
//   arm           level; requests armed operation
//   wr_valid      write strobe for staging[wr_ch]
//   wr_ch         staging channel index
//   wr_data       pulse width in ticks
//   commit        pulse; apply the staging widths at the next boundary
//   period        period in ticks, sampled at each boundary (values < 2 ignored)
//   pwm_out       registered motor PWM outputs
//   period_start  one-cycle pulse marking the first output cycle of a period
//   armed         high while ARMED
//   failsafe      high while FAILSAFE
//   wr_err        one-cycle pulse after a write to a nonexistent channel
module motor_pwm_gen #(
  parameter int unsigned NUM_CH         = 6,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE       = 100,
  parameter int unsigned PERIOD_DEFAULT = 2500,
  parameter int unsigned IDLE_WIDTH     = 1000,
  parameter int unsigned WDOG_PERIODS   = 50,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              arm,
  input  logic              wr_valid,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              commit,
  input  logic [WIDTH-1:0]  period,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              armed,
  output logic              failsafe,
  output logic              wr_err
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WD_W = (WDOG_PERIODS > 0) ? $clog2(WDOG_PERIODS + 1) : 1;

  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(WDOG_PERIODS);
  localparam logic [WIDTH-1:0] IDLE_W     = WIDTH'(IDLE_WIDTH);
  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_DEFAULT);
  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FAILSAFE = 2'd2
  } state_e;

  state_e            state;
  state_e            state_d;

  logic [PS_W-1:0]   presc;
  logic [WIDTH-1:0]  pcnt;
  logic [WIDTH-1:0]  period_q;
  logic [WD_W-1:0]   wdog;
  logic [WD_W-1:0]   wdog_inc;
  logic [WD_W-1:0]   wdog_d;
  logic              commit_pending;

  logic [WIDTH-1:0]  staging  [NUM_CH];
  logic [WIDTH-1:0]  shadow   [NUM_CH];
  logic [WIDTH-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_d;

  logic              tick;
  logic              boundary;
  logic              apply;
  logic              wdog_trip;
  logic              enter_disarm;
  logic              ch_ok;

  // ---------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------
  assign tick     = (presc == PS_LAST);
  assign boundary = (presc == '0) && (pcnt == '0);
  assign apply    = boundary && commit_pending;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // The wrap point uses the period latched at the last boundary, so a new
  // period value never truncates or stretches the period in progress.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pcnt <= '0;
    end else if (tick) begin
      if (pcnt >= period_q - WIDTH'(1)) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      period_q <= PERIOD_RST;
    end else if (boundary && (period >= MIN_PERIOD)) begin
      period_q <= period;
    end
  end

  // ---------------------------------------------------------------------
  // Staging bank, commit request and write error
  // ---------------------------------------------------------------------
  assign ch_ok = (32'(wr_ch) < NUM_CH);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        staging[i] <= '0;
      end
    end else if (wr_valid && ch_ok) begin
      staging[wr_ch] <= wr_data;
    end
  end

  // A commit arriving on the boundary cycle survives the clear and is
  // therefore applied at the following boundary.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      commit_pending <= 1'b0;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end else if (boundary) begin
      commit_pending <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_valid && !ch_ok;
    end
  end

  // ---------------------------------------------------------------------
  // Refresh watchdog: counts boundaries without a commit, saturating
  // ---------------------------------------------------------------------
  assign wdog_inc  = (wdog >= WD_LIMIT) ? wdog : wdog + WD_W'(1);
  assign wdog_trip = boundary && !commit_pending && (wdog_inc == WD_LIMIT);

  always_comb begin
    wdog_d = wdog;
    if (apply) begin
      wdog_d = '0;
    end else if (boundary) begin
      wdog_d = wdog_inc;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog <= '0;
    end else begin
      wdog <= wdog_d;
    end
  end

  // ---------------------------------------------------------------------
  // Arming state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_DISARMED;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_DISARMED: begin
        if (apply && arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (wdog_trip) begin
          state_d = ST_FAILSAFE;
        end
      end
      ST_FAILSAFE: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (apply) begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase
  end

  assign enter_disarm = (state != ST_DISARMED) && (state_d == ST_DISARMED);

  // ---------------------------------------------------------------------
  // Shadow bank and output compare
  // ---------------------------------------------------------------------
  // Disarming wins over a commit landing on the same boundary: the bank
  // is cleared, and the commit request is still consumed.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow[i];
      if (enter_disarm) begin
        shadow_d[i] = '0;
      end else if (apply) begin
        shadow_d[i] = staging[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= shadow_d[i];
      end
    end
  end

  // Outputs are computed from the next state and next shadow bank so a
  // state change or a commit shows up on the very next cycle, together
  // with the status flags.
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (state_d)
        ST_ARMED:    pwm_d[i] = (pcnt < shadow_d[i]);
        ST_FAILSAFE: pwm_d[i] = (pcnt < IDLE_W);
        default:     pwm_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      armed        <= 1'b0;
      failsafe     <= 1'b0;
    end else begin
      pwm_out      <= pwm_d;
      period_start <= boundary;
      armed        <= (state_d == ST_ARMED);
      failsafe     <= (state_d == ST_FAILSAFE);
    end
  end

endmodule
